spi_slave: RTL and testbench

Receive/transmit end of the SPI link: the peripheral-side counterpart of the SPI master core. Oversamples the external `sck_in`, `ss_in` and `mosi_in` pins on `clk_in`, shifts one 8-bit frame per selection window in all four CPOL/CPHA modes, and drives `miso_out` from a single-entry transmit buffer. Sits between the SPI pins and the register block, which supplies `spi_cr1_in` and moves data over valid/ready handshakes.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sync.sv | 22 ++
 rtl/spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: CR1 bit positions, slave state encoding
// and bit-order helpers for the shift path.
package spi_pkg;

  localparam int CR1_SPE   = 7;
  localparam int CR1_CPOL  = 5;
  localparam int CR1_CPHA  = 4;
  localparam int CR1_LSBFE = 2;

  typedef enum logic [1:0] {
    ST_DISABLE = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACTIVE  = 2'd2
  } spi_state_e;

  // Bit that leaves the shift register next.
  function automatic logic out_bit(
    input logic [7:0] x,
    input logic       lsb
  );
    return lsb ? x[0] : x[7];
  endfunction

  // Shift register after its outgoing bit is gone.
  function automatic logic [7:0] shift_out(
    input logic [7:0] x,
    input logic       lsb
  );
    return lsb ? {1'b0, x[7:1]} : {x[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with a selectable reset level.
// Ports: clk, rst_n, rst_val (reset level), d (async in), q (synced out).
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{rst_val}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled pins, 8-bit frames in all CPOL/CPHA modes.
// Ports: clk_in/rstn_in, spi_cr1_in, tx/rx valid-ready, overrun, SPI pins.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic [7:0] spi_cr1_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  input  logic       rx_ready_in,
  input  logic       ovr_clr_in,
  output logic       overrun_out,
  output logic       busy_out,
  input  logic       sck_in,
  input  logic       ss_in,
  input  logic       mosi_in,
  output logic       miso_out,
  output logic       miso_oe_out
);

  spi_state_e state, state_nxt;

  logic sck_s, ss_s, mosi_s, sck_q, ss_q;
  logic cpol_r, cpha_r, lsb_r;
  logic [3:0] cnt;
  logic [7:0] tx_sr, rx_sr, tx_buf, load_val, rx_nxt;
  logic tx_full, miso_r;
  logic spe, ss_fall, ss_rise, start, active;
  logic edge_det, lead, samp, shft, done, load;
  logic lsb_u, cpha_u, tx_acc, ovr_set;
  logic unused_cr1;

  assign unused_cr1 = ^{spi_cr1_in[6], spi_cr1_in[3],
                        spi_cr1_in[1:0]};

  spi_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk_in), .rst_n(rstn_in),
    .rst_val(spi_cr1_in[CR1_CPOL]), .d(sck_in), .q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk_in), .rst_n(rstn_in),
    .rst_val(1'b1), .d(ss_in), .q(ss_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk_in), .rst_n(rstn_in),
    .rst_val(1'b0), .d(mosi_in), .q(mosi_s)
  );

  assign spe     = spi_cr1_in[CR1_SPE];
  assign ss_fall = ss_q & ~ss_s;
  assign ss_rise = ~ss_q & ss_s;
  assign start   = spe & (state == ST_IDLE) & ss_fall;
  assign active  = spe & (state == ST_ACTIVE) & ~ss_rise;

  assign edge_det = active & (sck_s ^ sck_q);
  assign lead     = sck_s ^ cpol_r;
  // CPHA=0 samples leading edges, CPHA=1 samples trailing edges.
  assign samp     = edge_det & (lead ^ cpha_r);
  assign shft     = edge_det & ~(lead ^ cpha_r);
  assign done     = edge_det & (cnt == 4'd15);
  assign load     = start | done;

  // Mode bits are taken live at frame start, latched afterwards.
  assign lsb_u  = start ? spi_cr1_in[CR1_LSBFE] : lsb_r;
  assign cpha_u = start ? spi_cr1_in[CR1_CPHA] : cpha_r;

  assign load_val = tx_full ? tx_buf : 8'hFF;
  assign rx_nxt   = !samp  ? rx_sr :
                    lsb_r  ? {mosi_s, rx_sr[7:1]} :
                             {rx_sr[6:0], mosi_s};

  assign tx_acc  = spe & tx_valid_in & ~tx_full;
  assign ovr_set = done & rx_valid_out & ~rx_ready_in;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state <= ST_DISABLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_DISABLE: if (spe) state_nxt = ST_IDLE;
      ST_IDLE:    if (ss_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE:  if (ss_rise) state_nxt = ST_IDLE;
      default:    state_nxt = ST_DISABLE;
    endcase
    if (!spe) state_nxt = ST_DISABLE;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      sck_q <= spi_cr1_in[CR1_CPOL];
      ss_q  <= 1'b1;
    end else begin
      sck_q <= sck_s;
      ss_q  <= ss_s;
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      cpol_r  <= 1'b0;
      cpha_r  <= 1'b0;
      lsb_r   <= 1'b0;
      cnt     <= 4'd0;
      rx_sr   <= 8'h00;
      tx_sr   <= 8'h00;
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
      miso_r  <= 1'b1;
    end else if (!spe) begin
      cnt     <= 4'd0;
      rx_sr   <= 8'h00;
      tx_sr   <= 8'h00;
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
      miso_r  <= 1'b1;
    end else begin
      if (start) begin
        cpol_r <= spi_cr1_in[CR1_CPOL];
        cpha_r <= spi_cr1_in[CR1_CPHA];
        lsb_r  <= spi_cr1_in[CR1_LSBFE];
        cnt    <= 4'd0;
        rx_sr  <= 8'h00;
      end else if (edge_det) begin
        cnt   <= cnt + 4'd1;
        rx_sr <= rx_nxt;
      end
      // CPHA=0 puts the first bit out at load time; CPHA=1
      // waits for the first leading edge.
      if (load) begin
        if (!cpha_u) begin
          miso_r <= out_bit(load_val, lsb_u);
          tx_sr  <= shift_out(load_val, lsb_u);
        end else begin
          tx_sr  <= load_val;
        end
      end else if (shft) begin
        miso_r <= out_bit(tx_sr, lsb_r);
        tx_sr  <= shift_out(tx_sr, lsb_r);
      end
      if (load)   tx_full <= 1'b0;
      if (tx_acc) begin
        tx_full <= 1'b1;
        tx_buf  <= tx_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      rx_data_out  <= 8'h00;
      rx_valid_out <= 1'b0;
      overrun_out  <= 1'b0;
    end else if (!spe) begin
      rx_valid_out <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      if (done && !ovr_set) begin
        rx_data_out  <= rx_nxt;
        rx_valid_out <= 1'b1;
      end else if (rx_valid_out && rx_ready_in) begin
        rx_valid_out <= 1'b0;
      end
      if (ovr_set)         overrun_out <= 1'b1;
      else if (ovr_clr_in) overrun_out <= 1'b0;
    end
  end

  assign tx_ready_out = ~tx_full;
  assign busy_out     = (state == ST_ACTIVE);
  assign miso_out     = miso_r;
  assign miso_oe_out  = spe & ~ss_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of per-mode frames plus
// hand sequences for overrun, partial frames, disable and reset.
module tb_spi_slave;

  logic       clk_in = 1'b0;
  logic       rstn_in = 1'b0;
  logic [7:0] spi_cr1_in = 8'h00;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx_valid_in = 1'b0;
  logic       tx_ready_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_ready_in = 1'b0;
  logic       ovr_clr_in = 1'b0;
  logic       overrun_out;
  logic       busy_out;
  logic       sck_in = 1'b0;
  logic       ss_in = 1'b1;
  logic       mosi_in = 1'b0;
  logic       miso_out;
  logic       miso_oe_out;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in),
    .spi_cr1_in(spi_cr1_in),
    .tx_data_in(tx_data_in), .tx_valid_in(tx_valid_in),
    .tx_ready_out(tx_ready_out),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
    .rx_ready_in(rx_ready_in),
    .ovr_clr_in(ovr_clr_in), .overrun_out(overrun_out),
    .busy_out(busy_out),
    .sck_in(sck_in), .ss_in(ss_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .miso_oe_out(miso_oe_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int rv_rises = 0;
  logic rv_prev = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;

  always @(posedge clk_in) begin
    if (rx_valid_out && !rv_prev) rv_rises++;
    rv_prev <= rx_valid_out;
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h",
               name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Half SCK period = 6 system clocks.
  task automatic half();
    cyc(6);
  endtask

  task automatic cfg(input logic p, input logic h, input logic l);
    cpol = p; cpha = h; lsb = l;
    sck_in = p;
    cyc(4);
    spi_cr1_in = 8'h80 | ({7'd0, p} << 5) |
                 ({7'd0, h} << 4) | ({7'd0, l} << 2);
    cyc(4);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk_in);
    tx_data_in = d;
    tx_valid_in = 1'b1;
    @(negedge clk_in);
    tx_valid_in = 1'b0;
  endtask

  task automatic rd_rx();
    @(negedge clk_in);
    rx_ready_in = 1'b1;
    @(negedge clk_in);
    rx_ready_in = 1'b0;
  endtask

  task automatic sel();
    ss_in = 1'b0;
    half();
  endtask

  task automatic desel();
    half();
    ss_in = 1'b1;
    half();
  endtask

  // Master side of nbits bit periods; selection handled outside.
  task automatic xfer(input logic [7:0] m, input int nbits,
                      output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi_in = m[b];
        half();
        s[b] = miso_out;
        sck_in = ~cpol;
        half();
        sck_in = cpol;
      end else begin
        mosi_in = m[b];
        sck_in = ~cpol;
        half();
        s[b] = miso_out;
        sck_in = cpol;
        half();
      end
    end
  endtask

  logic [7:0] s1, s2;
  int rv0;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h0F, 8'h81, 8'h0F};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h5A, 8'hC3, 8'h5A, 8'hC3};

    cyc(3);
    check("rst_tx_ready", tx_ready_out, 1);
    check("rst_rx_data", rx_data_out, 8'h00);
    check("rst_rx_valid", rx_valid_out, 0);
    check("rst_overrun", overrun_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_miso", miso_out, 1);
    check("rst_miso_oe", miso_oe_out, 0);
    rstn_in = 1'b1;
    cyc(2);

    foreach (vecs[k]) begin
      cfg(vecs[k].cpol, vecs[k].cpha, vecs[k].lsb);
      write_tx(vecs[k].tx);
      check("vec_tx_full", tx_ready_out, 0);
      rv0 = rv_rises;
      sel();
      check("vec_busy", busy_out, 1);
      check("vec_oe", miso_oe_out, 1);
      xfer(vecs[k].mo, 8, s1);
      check("vec_tx_ready", tx_ready_out, 1);
      desel();
      check("vec_miso", s1, vecs[k].exp_miso);
      check("vec_rx_data", rx_data_out, vecs[k].exp_rx);
      check("vec_rx_valid", rx_valid_out, 1);
      check("vec_rv_once", 8'(rv_rises - rv0), 8'd1);
      check("vec_ovr", overrun_out, 0);
      rd_rx();
      check("vec_rx_read", rx_valid_out, 0);
    end

    // Overrun inside one window; full-buffer write ignored.
    cfg(1'b0, 1'b0, 1'b0);
    write_tx(8'h12);
    write_tx(8'h34);
    check("ovr_tx_full", tx_ready_out, 0);
    sel();
    xfer(8'h11, 8, s1);
    xfer(8'h55, 8, s2);
    desel();
    check("ovr_miso1", s1, 8'h12);
    check("ovr_miso2_empty", s2, 8'hFF);
    check("ovr_rx_keep", rx_data_out, 8'h11);
    check("ovr_rx_valid", rx_valid_out, 1);
    check("ovr_flag", overrun_out, 1);
    @(negedge clk_in);
    ovr_clr_in = 1'b1;
    @(negedge clk_in);
    ovr_clr_in = 1'b0;
    check("ovr_cleared", overrun_out, 0);
    rd_rx();
    check("ovr_rx_read", rx_valid_out, 0);

    // Deselect after 5 bits, then a clean frame.
    cfg(1'b0, 1'b1, 1'b0);
    rv0 = rv_rises;
    sel();
    xfer(8'hAA, 5, s1);
    desel();
    check("part_rx_valid", rx_valid_out, 0);
    check("part_rv_none", 8'(rv_rises - rv0), 8'd0);
    check("part_ovr", overrun_out, 0);
    write_tx(8'h69);
    sel();
    xfer(8'h96, 8, s1);
    desel();
    check("part_next_miso", s1, 8'h69);
    check("part_next_rx", rx_data_out, 8'h96);
    check("part_next_valid", rx_valid_out, 1);

    // SPE dropped mid-frame with both flags set.
    sel();
    xfer(8'h01, 8, s1);
    check("spe_ovr_set", overrun_out, 1);
    write_tx(8'h44);
    xfer(8'h02, 3, s1);
    check("spe_tx_full", tx_ready_out, 0);
    spi_cr1_in = 8'h00;
    cyc(2);
    check("spe_oe", miso_oe_out, 0);
    check("spe_rx_valid", rx_valid_out, 0);
    check("spe_ovr", overrun_out, 0);
    check("spe_tx_ready", tx_ready_out, 1);
    check("spe_busy", busy_out, 0);
    desel();

    // Reset mid-frame.
    cfg(1'b0, 1'b0, 1'b0);
    write_tx(8'h77);
    sel();
    xfer(8'hF0, 8, s1);
    xfer(8'h0F, 3, s1);
    check("mid_busy", busy_out, 1);
    check("mid_rx_valid", rx_valid_out, 1);
    rstn_in = 1'b0;
    #1;
    check("mrst_tx_ready", tx_ready_out, 1);
    check("mrst_rx_data", rx_data_out, 8'h00);
    check("mrst_rx_valid", rx_valid_out, 0);
    check("mrst_overrun", overrun_out, 0);
    check("mrst_busy", busy_out, 0);
    check("mrst_miso", miso_out, 1);
    check("mrst_miso_oe", miso_oe_out, 0);
    ss_in = 1'b1;
    sck_in = 1'b0;
    cyc(3);
    rstn_in = 1'b1;
    cyc(4);

    write_tx(8'h3C);
    sel();
    xfer(8'hC3, 8, s1);
    desel();
    check("post_miso", s1, 8'h3C);
    check("post_rx", rx_data_out, 8'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
